// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the two-port multiplier scheduler.
package mult_sched_pkg;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned OP_W      = 32;
  localparam int unsigned PROD_W    = 64;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            sgn;
  } req_t;

  // Unsigned magnitude of an operand; -2^31 maps to 0x8000_0000.
  function automatic logic [OP_W-1:0] magnitude(input logic [OP_W-1:0] x, input logic sgn);
    return (sgn & x[OP_W-1]) ? (~x + OP_W'(1)) : x;
  endfunction

endpackage

// File: rtl/mult_sched_multiplier.sv
// Shared combinational 32x32 unsigned array multiplier.
module multiplier
  import mult_sched_pkg::*;
(
  input  logic [OP_W-1:0]   in1,
  input  logic [OP_W-1:0]   in2,
  output logic [PROD_W-1:0] out
);

  assign out = {{(PROD_W-OP_W){1'b0}}, in1} * {{(PROD_W-OP_W){1'b0}}, in2};

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one unsigned multiplier between two ports,
// with sign-magnitude handling and a multicycle operand hold window.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_valid,
  output logic [NUM_PORTS-1:0] req_ready,
  input  logic [OP_W-1:0]      req_a0,
  input  logic [OP_W-1:0]      req_b0,
  input  logic [OP_W-1:0]      req_a1,
  input  logic [OP_W-1:0]      req_b1,
  input  logic [NUM_PORTS-1:0] req_signed,
  input  logic                 flush,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [PROD_W-1:0]    rsp_product,
  output logic                 busy
);

  state_e             state_q, state_d;
  logic               last_grant_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [OP_W-1:0]    mag_a_q, mag_b_q;
  logic               neg_q;
  logic               id_q;
  logic [PROD_W-1:0]  arr_out;

  logic               grant;
  logic               accept;
  logic               capture;
  req_t               sel;

  // Arbitration: a lone requester wins; on contention the port not granted last wins.
  always_comb begin
    grant     = 1'b0;
    req_ready = '0;
    sel       = '0;
    if (req_valid == 2'b11) begin
      grant = ~last_grant_q;
    end else begin
      grant = req_valid[1];
    end
    sel = grant ? '{a: req_a1, b: req_b1, sgn: req_signed[1]}
                : '{a: req_a0, b: req_b0, sgn: req_signed[0]};
    if (rst_n && (state_q == IDLE) && !flush && (|req_valid)) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept = |req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over the capture in BUSY; in DONE it coincides with the handshake exit.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          capture = 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      mag_a_q      <= '0;
      mag_b_q      <= '0;
      neg_q        <= 1'b0;
      id_q         <= 1'b0;
      rsp_product  <= '0;
      rsp_id       <= 1'b0;
    end else begin
      if (accept) begin
        mag_a_q      <= magnitude(sel.a, sel.sgn);
        mag_b_q      <= magnitude(sel.b, sel.sgn);
        neg_q        <= sel.sgn & (sel.a[OP_W-1] ^ sel.b[OP_W-1]);
        id_q         <= grant;
        last_grant_q <= grant;
        cnt_q        <= CNT_W'(LATENCY - 1);
      end else if ((state_q == BUSY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (capture) begin
        rsp_product <= neg_q ? (~arr_out + PROD_W'(1)) : arr_out;
        rsp_id      <= id_q;
      end
    end
  end

  // Array inputs come straight from registers held from acceptance to capture.
  multiplier u_multiplier (
    .in1 (mag_a_q),
    .in2 (mag_b_q),
    .out (arr_out)
  );

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: random operands against an arithmetic
// reference product plus a round-robin grant model.
module tb_mult_sched;

  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_signed;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [63:0] rsp_product;
  logic        busy;

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic model_last;

  mult_sched #(.LATENCY(LATENCY)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a0      (req_a0),
    .req_b0      (req_b0),
    .req_a1      (req_a1),
    .req_b1      (req_b1),
    .req_signed  (req_signed),
    .flush       (flush),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Drive a single-port request from a negedge; returns at the negedge after acceptance.
  task automatic accept(input int port, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, output bit ok);
    ok = 1'b0;
    req_valid = 2'b00;
    if (port == 0) begin req_a0 = a; req_b0 = b; end
    else           begin req_a1 = a; req_b1 = b; end
    req_signed[port] = sgn;
    req_valid[port]  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready[port]) begin
        @(posedge clk);
        #1 req_valid = 2'b00;
        model_last = 1'(port);
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout port=%0d req_ready=%b required=grant", port, req_ready);
    end
  endtask

  // Step negedges until rsp_valid; lat counts edges since acceptance.
  task automatic wait_rsp(output int lat, output logic [63:0] prod, output logic id, output bit ok);
    ok = 1'b0; lat = -1; prod = '0; id = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid) begin
        lat = k; prod = rsp_product; id = rsp_id; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout rsp_valid=%b required=1", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; flush = 1'b0; rsp_ready = 1'b1;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_signed = 2'b00;
    model_last = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (rsp_product !== 64'd0 || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp got=%h/%b exp=0/0", rsp_product, rsp_id);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok; int lat; logic [63:0] p; logic id;
    rsp_ready = 1'b1;
    accept(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, ok);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", busy); end
    wait_rsp(lat, p, id, ok);
    n_cmp++; if (lat != int'(LATENCY)) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LATENCY); end
    n_cmp++; if (p !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL basic_product got=%h exp=fffffffe00000001", p); end
    n_cmp++; if (id !== 1'b0) begin n_fail++; $display("FAIL basic_id got=%b exp=0", id); end
    req_a0 = 32'd5; req_b0 = 32'd6; req_signed[0] = 1'b0; req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL basic_done_block got=%b exp=00", req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 2'b01 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_next_accept ready=%b busy=%b valid=%b exp=01/0/0", req_ready, busy, rsp_valid);
    end
    @(posedge clk); #1 req_valid = 2'b00; model_last = 1'b0;
    @(negedge clk);
    wait_rsp(lat, p, id, ok);
    n_cmp++; if (p !== 64'd30 || lat != int'(LATENCY)) begin
      n_fail++; $display("FAIL basic_second got=%h lat=%0d exp=1e lat=%0d", p, lat, LATENCY);
    end
    @(negedge clk);
  endtask

  task automatic test_signed();
    bit ok; int lat; logic [63:0] p; logic id;
    rsp_ready = 1'b1;
    accept(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, ok);
    wait_rsp(lat, p, id, ok);
    n_cmp++; if (p !== 64'h0000_0000_8000_0000 || id !== 1'b1) begin
      n_fail++; $display("FAIL signed_min_x_m1 got=%h id=%b exp=0000000080000000 id=1", p, id);
    end
    @(negedge clk);
    accept(0, 32'hFFFF_FFFD, 32'd7, 1'b1, ok);
    wait_rsp(lat, p, id, ok);
    n_cmp++; if (p !== 64'hFFFF_FFFF_FFFF_FFEB || id !== 1'b0) begin
      n_fail++; $display("FAIL signed_m3_x_7 got=%h id=%b exp=ffffffffffffffeb id=0", p, id);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ok; int lat; logic [63:0] p, e; logic id;
    int port; logic [31:0] a, b; logic s;
    rsp_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      port = int'($urandom_range(0, 1));
      a = pick(); b = pick(); s = 1'($urandom_range(0, 1));
      e = ref_prod(a, b, s);
      accept(port, a, b, s, ok);
      wait_rsp(lat, p, id, ok);
      n_cmp++; if (p !== e || id !== 1'(port) || lat != int'(LATENCY)) begin
        n_fail++;
        $display("FAIL random_op%0d a=%h b=%h s=%b got=%h id=%b lat=%0d exp=%h id=%0d lat=%0d",
                 i, a, b, s, p, id, lat, e, port, LATENCY);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_p[$];
    logic        exp_i[$];
    logic        exp_g, refresh_pending, refresh_port;
    int          n_rsp;
    rsp_ready = 1'b1;
    refresh_pending = 1'b0; refresh_port = 1'b0; n_rsp = 0;
    req_a0 = $urandom; req_b0 = $urandom; req_a1 = $urandom; req_b1 = $urandom;
    req_signed = 2'($urandom_range(0, 3));
    req_valid = 2'b11;
    for (int c = 0; c < 200 && n_rsp < 8; c++) begin
      if (refresh_pending) begin
        if (refresh_port) begin req_a1 = $urandom; req_b1 = $urandom; req_signed[1] = 1'($urandom); end
        else              begin req_a0 = $urandom; req_b0 = $urandom; req_signed[0] = 1'($urandom); end
        refresh_pending = 1'b0;
      end
      #1;
      if (rsp_valid) begin
        n_rsp++;
        n_cmp++;
        if (exp_p.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected_rsp got=%h id=%b exp=none", rsp_product, rsp_id);
        end else begin
          if (rsp_product !== exp_p[0] || rsp_id !== exp_i[0]) begin
            n_fail++; $display("FAIL b2b_rsp got=%h id=%b exp=%h id=%b", rsp_product, rsp_id, exp_p[0], exp_i[0]);
          end
          void'(exp_p.pop_front()); void'(exp_i.pop_front());
        end
        if (n_rsp == 8) req_valid = 2'b00;
      end
      if (req_ready != 2'b00) begin
        exp_g = ~model_last;
        n_cmp++;
        if (req_ready !== (exp_g ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL b2b_grant got=%b exp=%b", req_ready, exp_g ? 2'b10 : 2'b01);
        end
        exp_p.push_back(exp_g ? ref_prod(req_a1, req_b1, req_signed[1]) : ref_prod(req_a0, req_b0, req_signed[0]));
        exp_i.push_back(exp_g);
        model_last = exp_g;
        refresh_pending = 1'b1; refresh_port = exp_g;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    n_cmp++; if (n_rsp != 8) begin n_fail++; $display("FAIL b2b_count got=%0d exp=8", n_rsp); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    bit ok; int lat; logic [63:0] p, e; logic id; logic [31:0] a, b;
    rsp_ready = 1'b0;
    a = $urandom; b = $urandom; e = ref_prod(a, b, 1'b1);
    accept(1, a, b, 1'b1, ok);
    wait_rsp(lat, p, id, ok);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_product !== e || rsp_id !== 1'b1 || req_ready !== 2'b00 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold%0d valid=%b prod=%h id=%b ready=%b busy=%b exp=1/%h/1/00/1",
                 i, rsp_valid, rsp_product, rsp_id, req_ready, busy, e);
      end
    end
    rsp_ready = 1'b1; req_valid = 2'b00;
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_release valid=%b busy=%b exp=0/0", rsp_valid, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit ok, seen; int lat; logic [63:0] p, e; logic id; logic [31:0] a, b;
    rsp_ready = 1'b1;
    accept(0, 32'd1234, 32'd5678, 1'b0, ok);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_busy busy=%b valid=%b exp=0/0", busy, rsp_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < int'(LATENCY) + 3; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL flush_no_rsp got=1 exp=0"); end
    req_a0 = 32'd9; req_b0 = 32'd9; req_signed[0] = 1'b0; req_valid = 2'b01; flush = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL flush_idle_block got=%b exp=00", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_accepted busy=%b exp=0", busy); end
    flush = 1'b0; req_valid = 2'b00;
    @(negedge clk);
    a = pick(); b = $urandom; e = ref_prod(a, b, 1'b1);
    accept(1, a, b, 1'b1, ok);
    wait_rsp(lat, p, id, ok);
    n_cmp++; if (p !== e || id !== 1'b1) begin
      n_fail++; $display("FAIL flush_after got=%h id=%b exp=%h id=1", p, id, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_done();
    bit ok; int lat; logic [63:0] p; logic id;
    rsp_ready = 1'b0;
    accept(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, ok);
    wait_rsp(lat, p, id, ok);
    req_valid = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_product !== 64'd0 || req_ready !== 2'b00) begin
      n_fail++; $display("FAIL rst_in_done valid=%b busy=%b prod=%h ready=%b exp=0/0/0/00",
                         rsp_valid, busy, rsp_product, req_ready);
    end
    model_last = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_first_grant got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_random();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
# mult_sched

Scheduler that shares the single combinational 32x32 unsigned `multiplier` between two requesters, e.g. the execute stage (port 0) and the HI/LO move/accumulate path (port 1). It arbitrates round-robin, registers operands, and adds signed support by sign-magnitude conversion around the unsigned array. It holds the operands stable for a fixed multicycle window, then delivers one registered 64-bit product per operation through a valid/ready response port.

## Interface
- `LATENCY`, default 2: cycles from request acceptance to `rsp_valid`. Legal range 1..15; it equals the multicycle-path budget of the array.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  2: per-port request valid.
- `req_ready`  out  2: per-port accept, at most one bit high.
- `req_a0`, `req_b0`  in  32 each: port 0 operands.
- `req_a1`, `req_b1`  in  32 each: port 1 operands.
- `req_signed`  in  2: per-port flag; 1 means operands are two's complement.
- `flush`  in  1: abort any in-flight or pending operation.
- `rsp_valid`  out  1: product available.
- `rsp_ready`  in  1: consumer accepts the product.
- `rsp_id`  out  1: port that issued the delivered product.
- `rsp_product`  out  64: product.
- `busy`  out  1: state is not IDLE.

## Operation
- FSM states:
  - IDLE: no operation held.
  - BUSY: operands registered, counter running.
  - DONE: product registered, `rsp_valid`=1.
- IDLE:
  - Grant the requesting port. If both request, grant the port not granted last. `last_grant` resets to 1, so port 0 wins first.
  - `req_ready[g]` = IDLE & `req_valid[g]` & !`flush`, combinational.
  - On handshake, register `|a|`, `|b|`, `neg = signed & (a[31]^b[31])` and `id`. Load `cnt` = LATENCY-1, go to BUSY, update `last_grant`.
- BUSY:
  - Decrement `cnt` each cycle.
  - When `cnt`==0, capture the array output into `rsp_product`, negated (two's complement, 64-bit) if `neg`, and go to DONE.
- DONE:
  - Hold `rsp_valid`, `rsp_id` and `rsp_product` stable until `rsp_valid & rsp_ready`, then go to IDLE.
  - No new request is accepted in DONE.
- Magnitude rule: `|x|` = signed & x[31] ? ~x+1 : x, in 32 unsigned bits. For -2^31 this gives 0x8000_0000, which is correct.
- Unsigned ops ignore bit 31 as a sign. Zero operands are never negated, so -0 stays 0.
- `flush`:
  - In BUSY or DONE, go to IDLE at the next edge and drop `rsp_valid`. `last_grant` keeps its updated value.
  - In IDLE, block acceptance for that cycle.
  - If `flush` and the response handshake occur on the same edge, the response counts as delivered and `flush` has no further effect.
- Reset (async, `rst_n`=0):
  - state IDLE.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `busy`=0.
  - `req_ready` forced to 2'b00 while `rst_n`=0.
  - `last_grant`=1.
- Reset during BUSY or DONE discards the operation with no response.

## Timing
- Request accepted at edge E0. `rsp_valid` rises after edge E_LATENCY.
- Earliest response handshake is E_LATENCY+1 (`rsp_ready` held high). Earliest next acceptance is E_LATENCY+2.
- Peak throughput is one op per LATENCY+2 cycles.
- Array inputs come only from registers and are stable from E0 to E_LATENCY. The array path is a LATENCY-cycle multicycle path.
- `req_ready` depends combinationally on `req_valid`, `flush` and state. No other output is combinational.
- `busy` is registered-state derived and is high from after E0 until the cycle after the response handshake or `flush`.

## Structure
- `mult_sched_pkg`:
  - state enum `{IDLE, BUSY, DONE}`.
  - `NUM_PORTS`=2.
  - `OP_W`=32, `PROD_W`=64.
  - `CNT_W`=4.
- One sub-module: the existing `multiplier`, instantiated unchanged (`in1`=`|a|` reg, `in2`=`|b|` reg, `out`).
- Arbiter, counter, sign handling and response register live in `mult_sched`.

## Test plan
- Port 0 only, unsigned, a=0xFFFF_FFFF, b=0xFFFF_FFFF, LATENCY=2, `rsp_ready`=1 -> `rsp_valid` after E2, `rsp_product`=0xFFFF_FFFE_0000_0001, `rsp_id`=0. Next accept no earlier than E4.
- Signed a=-2^31, b=-1 on port 1 -> 0x0000_0000_8000_0000. Signed a=-3, b=7 -> 0xFFFF_FFFF_FFFF_FFEB.
- Both ports valid continuously -> grants alternate 0,1,0,1 and `rsp_id` sequence matches.
- `rsp_ready`=0 for 5 cycles in DONE -> outputs stable, `req_ready`=00, no new accept. Product delivered on the first cycle `rsp_ready`=1.
- `flush` pulse mid-BUSY -> IDLE next edge, no `rsp_valid`. Subsequent request gets the correct product.
- `rst_n` asserted asynchronously in DONE -> `rsp_valid`, `busy` and `rsp_product` go to 0 immediately. The first grant after release goes to port 0.
